// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: fetch stage with loadable instruction memory and a prefetch FIFO feeding decode
module instruction_fetch_queue #(
    parameter int SIZE = 32,
    parameter int MAX_INSTRUCTION = 64,
    parameter int QUEUE_DEPTH = 4,
    parameter int WRAP_MODE = 1,
    localparam int ADDR_WIDTH = $clog2(MAX_INSTRUCTION)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_jump_en,
    input  logic [SIZE-1:0]       i_jump_addr,
    input  logic                  i_inst_write_enable,
    input  logic [ADDR_WIDTH-1:0] i_write_addr,
    input  logic [SIZE-1:0]       i_write_data,
    output logic [SIZE-1:0]       o_instruction,
    output logic [SIZE-1:0]       o_pc,
    output logic [SIZE-1:0]       o_adder,
    output logic                  o_valid,
    output logic                  o_halted,
    output logic                  o_writing_instruction_mem
);
    localparam int QW = $clog2(QUEUE_DEPTH);

    typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

    state_t state, state_d;
    logic [SIZE-1:0]       mem    [MAX_INSTRUCTION];
    logic [SIZE-1:0]       q_inst [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
    logic [QW-1:0]         wr_ptr, rd_ptr;
    logic [QW:0]           count;
    logic [ADDR_WIDTH-1:0] fetch_pc, rd_pc;
    logic [SIZE-1:0]       rd_data;
    logic                  inflight, pop, issue, last;
    logic                  unused_jump_bits;

    assign unused_jump_bits = ^i_jump_addr[SIZE-1:ADDR_WIDTH];

    // Issue only if the entry landing this edge plus the new read still fit after the pop
    always_comb begin
        pop = o_valid && !i_stall;
        issue = state != HALT && (int'(count) - int'(pop) + int'(inflight) < QUEUE_DEPTH);
        last = &fetch_pc;
        state_d = i_inst_write_enable ? LOAD :
                  i_jump_en ? RUN :
                  (state == HALT || (issue && last && WRAP_MODE == 0)) ? HALT : RUN;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= RUN;
        else
            state <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < MAX_INSTRUCTION; i++)
                mem[i] <= '0;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            inflight <= 1'b0;
            fetch_pc <= '0;
            rd_pc <= '0;
            rd_data <= '0;
            o_writing_instruction_mem <= 1'b0;
        end else begin
            o_writing_instruction_mem <= i_inst_write_enable;
            if (i_inst_write_enable || i_jump_en) begin
                if (i_inst_write_enable)
                    mem[i_write_addr] <= i_write_data;
                count <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                inflight <= 1'b0;
                fetch_pc <= i_inst_write_enable ? '0 : i_jump_addr[ADDR_WIDTH-1:0];
            end else begin
                if (inflight) begin
                    q_inst[wr_ptr] <= rd_data;
                    q_pc[wr_ptr] <= rd_pc;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + (QW+1)'(inflight) - (QW+1)'(pop);
                inflight <= issue;
                if (issue) begin
                    rd_data <= mem[fetch_pc];
                    rd_pc <= fetch_pc;
                    fetch_pc <= fetch_pc + 1'b1;
                end
            end
        end
    end

    assign o_valid = count != '0;
    assign o_instruction = o_valid ? q_inst[rd_ptr] : '0;
    assign o_pc = o_valid ? SIZE'(q_pc[rd_ptr]) : '0;
    assign o_adder = o_valid ? o_pc + SIZE'(1) : '0;
    assign o_halted = state == HALT && count == '0 && !inflight;
endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Parametrised instruction fetch stage with a prefetch queue between the instruction memory and decode. It holds a word-addressed fetch PC and on-chip instruction memory with a loader write port. It prefetches into a QUEUE_DEPTH-entry FIFO of {pc, instruction} pairs and presents them to decode with a valid/stall handshake. It adds a jump flush, optional halt-at-end mode and throughput of one instruction per cycle under stall back-pressure.

Parameters:
SIZE, 32, instruction/PC width in bits
MAX_INSTRUCTION, 64, instruction memory depth in words; power of two
QUEUE_DEPTH, 4, prefetch FIFO entries; power of two, >= 2
WRAP_MODE, 1, 1 = fetch PC wraps MAX_INSTRUCTION-1 -> 0; 0 = fetch stops after MAX_INSTRUCTION-1
ADDR_WIDTH (localparam), $clog2(MAX_INSTRUCTION), memory address width

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_stall  in  1  decode not ready; head is not consumed while high
i_jump_en  in  1  redirect fetch to i_jump_addr and flush
i_jump_addr  in  SIZE  jump target, word address
i_inst_write_enable  in  1  loader mode; writes memory, fetch suspended
i_write_addr  in  ADDR_WIDTH  loader write address
i_write_data  in  SIZE  loader write data
o_instruction  out  SIZE  queue-head instruction; 0 when !o_valid
o_pc  out  SIZE  queue-head PC; 0 when !o_valid
o_adder  out  SIZE  o_pc + 1, no wrap; 0 when !o_valid
o_valid  out  1  queue head holds a valid instruction
o_halted  out  1  WRAP_MODE=0 only: fetch stopped and queue empty
o_writing_instruction_mem  out  1  equals i_inst_write_enable, registered

Behaviour:
- Reset has a single clock. Priority in a cycle is i_rst > i_inst_write_enable > i_jump_en > normal pop/fetch.
- Reset sets the following:
  - fetch PC = 0, queue empty, no read in flight, all memory words = 0.
  - All outputs = 0. State = RUN.
- States:
  - LOAD while i_inst_write_enable = 1.
  - RUN.
  - HALT, WRAP_MODE=0 only.
- LOAD behaviour:
  - Each cycle writes i_write_data to mem[i_write_addr].
  - Queue and in-flight read are flushed. Fetch PC is forced to 0. No reads are issued.
  - On deassertion the block goes to RUN and fetch restarts at address 0.
- Fetch issue (RUN): a synchronous read of mem[fetch PC] is issued when count + inflight < QUEUE_DEPTH, counted after this cycle's pop. Fetch PC then increments.
- Latency:
  - A read issued at edge N writes its entry into the queue at edge N+1.
  - o_valid is asserted after that edge.
  - First instruction is valid 2 cycles after reset release, LOAD exit or jump.
- Pop: when o_valid=1 and i_stall=0, the head is consumed at the edge. Pop and queue write may happen in the same cycle; count stays the same.
- Steady throughput is one instruction per cycle with i_stall=0. With i_stall=1 the queue fills to QUEUE_DEPTH and issue stops; nothing is lost or duplicated.
- Full/empty: count ranges 0..QUEUE_DEPTH. No write is ever issued into a full queue.
- Jump (i_jump_en=1 in RUN or HALT):
  - If the head is popped the same cycle, that pop counts as accepted.
  - The queue and any in-flight read are discarded at the edge.
  - Fetch PC <= i_jump_addr[ADDR_WIDTH-1:0]; the upper bits are ignored. State = RUN.
  - o_valid = 0 for the next 2 cycles.
- Wrap:
  - WRAP_MODE=1: after issuing address MAX_INSTRUCTION-1, fetch PC = 0.
  - WRAP_MODE=0: after issuing address MAX_INSTRUCTION-1, go to HALT and stop issuing. The queue drains normally.
  - o_halted = 1 when in HALT and count=0. A jump leaves HALT.
- Reset mid-operation takes effect at the next edge regardless of state, and the queue is cleared.

Test Plan:
- Reset, load mem[k]=0x100+k for k=0..7 via LOAD, release, i_stall=0:
  - o_valid first rises 2 cycles after release.
  - The block outputs (pc, instr) = (0,0x100),(1,0x101),... on consecutive cycles.
  - o_adder = pc+1.
- Back-pressure: hold i_stall=1 for 10 cycles mid-stream, then release:
  - The queue holds exactly QUEUE_DEPTH entries and the head is unchanged.
  - Resumes with no gaps, duplicates or skips.
- Jump: pulse i_jump_en with i_jump_addr=0x25 while the queue is full:
  - o_valid = 0 for 2 cycles.
  - Next delivered pc=0x25 with mem[0x25], then 0x26.
- Wrap, WRAP_MODE=1, MAX_INSTRUCTION=64: the sequence ...,62,63,0,1.
- Halt, WRAP_MODE=0:
  - The sequence ends at pc 63 and o_halted rises after the drain.
  - A jump to 5 resumes at 5 and o_halted = 0.
- Asserting i_rst with the queue half full and a read in flight:
  - The next cycle has all outputs 0, o_valid=0 and memory cleared.
  - Fetch restarts at 0.
